// File: rtl/mips_defs.sv
// mips_defs: MIPS opcode/funct constants, Tuse/Tnew and forward-select encodings,
// plus the per-instruction class record produced by instr_class.
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  typedef logic [1:0] t_t;
  // A source that is never read uses a Tuse larger than any Tnew, so it never stalls.
  localparam t_t TUSE_0    = 2'd0;
  localparam t_t TUSE_1    = 2'd1;
  localparam t_t TUSE_2    = 2'd2;
  localparam t_t TUSE_NONE = 2'd3;
  localparam t_t TNEW_0    = 2'd0;
  localparam t_t TNEW_1    = 2'd1;
  localparam t_t TNEW_2    = 2'd2;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;
  localparam logic FWD_M_PIPE = 1'b0;
  localparam logic FWD_M_W    = 1'b1;
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    t_t         tuse_rs;
    t_t         tuse_rt;
    t_t         tnew;
    logic       md;
    logic       md_acc;
    logic       div;
    logic       sw;
  } iclass_t;
  function automatic t_t tnew_after(t_t t);
    return t == TNEW_0 ? TNEW_0 : t - 2'd1;
  endfunction
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: pipeline IRs in, stall/forward controls out.
interface hazard_unit_if;
  logic [31:0] D_IR;
  logic [31:0] E_IR;
  logic [31:0] M_IR;
  logic [31:0] W_IR;
  logic        stall;
  logic        md_start;
  logic        md_busy;
  logic [1:0]  fwd_D_rs;
  logic [1:0]  fwd_D_rt;
  logic [1:0]  fwd_E_rs;
  logic [1:0]  fwd_E_rt;
  logic        fwd_M_rt;
  modport master (
    output D_IR, E_IR, M_IR, W_IR,
    input  stall, md_start, md_busy, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
  );
  modport slave (
    input  D_IR, E_IR, M_IR, W_IR,
    output stall, md_start, md_busy, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
  );
endinterface

// File: rtl/instr_class.sv
// instr_class: decodes one IR into sources, destination, Tuse/Tnew and MD class flags.
module instr_class
  import mips_defs::*;
(
  input  logic [31:0] ir_i,
  output iclass_t     cls_o
);
  logic [5:0] op, fn;
  logic r, addu, subu, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
  logic ori, lw, sw, lui, beq, jal;
  assign op    = ir_i[31:26];
  assign fn    = ir_i[5:0];
  assign r     = op == OP_RTYPE;
  assign addu  = r && fn == FN_ADDU;
  assign subu  = r && fn == FN_SUBU;
  assign jr    = r && fn == FN_JR;
  assign mult  = r && fn == FN_MULT;
  assign multu = r && fn == FN_MULTU;
  assign div   = r && fn == FN_DIV;
  assign divu  = r && fn == FN_DIVU;
  assign mfhi  = r && fn == FN_MFHI;
  assign mflo  = r && fn == FN_MFLO;
  assign mthi  = r && fn == FN_MTHI;
  assign mtlo  = r && fn == FN_MTLO;
  assign ori   = op == OP_ORI;
  assign lw    = op == OP_LW;
  assign sw    = op == OP_SW;
  assign lui   = op == OP_LUI;
  assign beq   = op == OP_BEQ;
  assign jal   = op == OP_JAL;
  always_comb begin
    cls_o.rs      = ir_i[25:21];
    cls_o.rt      = ir_i[20:16];
    cls_o.dst     = (addu | subu | mfhi | mflo) ? ir_i[15:11] :
                    (ori | lw | lui) ? ir_i[20:16] : jal ? 5'd31 : 5'd0;
    cls_o.tuse_rs = (beq | jr) ? TUSE_0 :
                    (addu | subu | ori | lw | sw | mthi | mtlo | mult | multu | div | divu) ? TUSE_1 :
                    TUSE_NONE;
    cls_o.tuse_rt = beq ? TUSE_0 : (addu | subu | mult | multu | div | divu) ? TUSE_1 :
                    sw ? TUSE_2 : TUSE_NONE;
    // Non-writers carry dst 0, so their Tnew never takes part in a match.
    cls_o.tnew    = (lui | jal) ? TNEW_0 : lw ? TNEW_2 : TNEW_1;
    cls_o.md      = mult | multu | div | divu;
    cls_o.md_acc  = mfhi | mflo | mthi | mtlo;
    cls_o.div     = div | divu;
    cls_o.sw      = sw;
  end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: MIPS 5-stage stall/forward control with a multiply/divide busy counter.
module hazard_unit
  import mips_defs::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input logic          clk,
  input logic          reset,
  hazard_unit_if.slave hz
);
  iclass_t d, e, m, w;
  t_t tnew_m;
  logic md_start, stall_rs, stall_rt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic unused_bits;
  instr_class u_d (.ir_i(hz.D_IR), .cls_o(d));
  instr_class u_e (.ir_i(hz.E_IR), .cls_o(e));
  instr_class u_m (.ir_i(hz.M_IR), .cls_o(m));
  instr_class u_w (.ir_i(hz.W_IR), .cls_o(w));
  function automatic logic hit(logic [4:0] src, logic [4:0] dst);
    return dst != 5'd0 && dst == src;
  endfunction
  function automatic logic src_stall(logic [4:0] src, t_t tuse, iclass_t ce, iclass_t cm, t_t tm);
    return (hit(src, ce.dst) && tuse < ce.tnew) || (hit(src, cm.dst) && tuse < tm);
  endfunction
  // The nearest writer wins; if it is not ready yet the register file is selected and stall covers it.
  function automatic logic [1:0] fwd_d(logic [4:0] src, iclass_t ce, iclass_t cm, t_t tm, iclass_t cw);
    return hit(src, ce.dst) ? (ce.tnew == TNEW_0 ? FWD_E : FWD_RF) :
           hit(src, cm.dst) ? (tm == TNEW_0 ? FWD_M : FWD_RF) :
           hit(src, cw.dst) ? FWD_W : FWD_RF;
  endfunction
  function automatic logic [1:0] fwd_e(logic [4:0] src, iclass_t cm, iclass_t cw);
    return hit(src, cm.dst) ? FWD_M : hit(src, cw.dst) ? FWD_W : FWD_RF;
  endfunction
  assign tnew_m      = tnew_after(m.tnew);
  assign md_start    = e.md;
  assign stall_rs    = src_stall(d.rs, d.tuse_rs, e, m, tnew_m);
  assign stall_rt    = src_stall(d.rt, d.tuse_rt, e, m, tnew_m);
  assign hz.md_start = md_start;
  assign hz.md_busy  = cnt_q != '0;
  assign hz.stall    = stall_rs | stall_rt | ((d.md | d.md_acc) & (md_start | hz.md_busy));
  assign hz.fwd_D_rs = fwd_d(d.rs, e, m, tnew_m, w);
  assign hz.fwd_D_rt = fwd_d(d.rt, e, m, tnew_m, w);
  assign hz.fwd_E_rs = fwd_e(e.rs, m, w);
  assign hz.fwd_E_rt = fwd_e(e.rt, m, w);
  assign hz.fwd_M_rt = (m.sw && hit(m.rt, w.dst)) ? FWD_M_W : FWD_M_PIPE;
  assign unused_bits = ^{d, e, m, w};
  always_comb
    cnt_d = md_start ? (e.div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC)) :
            cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q;
  always_ff @(posedge clk)
    cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus random pipelines checked against a rule-level model.
module tb_hazard_unit;
  typedef enum int {K_NOP, K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_LUI, K_BEQ, K_J, K_JAL, K_JR,
                    K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MFLO, K_MTHI, K_MTLO} kind_e;
  localparam int NO_USE = 9;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int m_cnt = 0;
  hazard_unit_if hz ();
  hazard_unit_if hz2 ();
  hazard_unit dut (.clk(clk), .reset(reset), .hz(hz));
  hazard_unit #(.MULT_CYC(5), .DIV_CYC(15), .CNT_W(4)) dut2 (.clk(clk), .reset(reset), .hz(hz2));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic kind_e kind_of(logic [31:0] ir);
    if (ir[31:26] == 6'h00)
      case (ir[5:0])
        6'h21: return K_ADDU;
        6'h23: return K_SUBU;
        6'h08: return K_JR;
        6'h18: return K_MULT;
        6'h19: return K_MULTU;
        6'h1a: return K_DIV;
        6'h1b: return K_DIVU;
        6'h10: return K_MFHI;
        6'h12: return K_MFLO;
        6'h11: return K_MTHI;
        6'h13: return K_MTLO;
        default: return K_NOP;
      endcase
    case (ir[31:26])
      6'h0d: return K_ORI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h0f: return K_LUI;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic bit is_md(kind_e k);
    return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU};
  endfunction

  function automatic int tuse_of(kind_e k, int rt);
    if (rt == 0) begin
      if (k inside {K_BEQ, K_JR}) return 0;
      if (k inside {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_MTHI, K_MTLO, K_MULT, K_MULTU, K_DIV, K_DIVU}) return 1;
      return NO_USE;
    end
    if (k == K_BEQ) return 0;
    if (k inside {K_ADDU, K_SUBU, K_MULT, K_MULTU, K_DIV, K_DIVU}) return 1;
    if (k == K_SW) return 2;
    return NO_USE;
  endfunction

  function automatic int dst_of(logic [31:0] ir);
    kind_e k;
    k = kind_of(ir);
    if (k inside {K_ADDU, K_SUBU, K_MFHI, K_MFLO}) return int'(ir[15:11]);
    if (k inside {K_ORI, K_LW, K_LUI}) return int'(ir[20:16]);
    if (k == K_JAL) return 31;
    return 0;
  endfunction

  // Cycles until the result exists, seen from stage k (1=E, 2=M, 3=W).
  function automatic int tnew_at(int k, logic [31:0] ir);
    kind_e c;
    int t;
    c = kind_of(ir);
    t = (c inside {K_LUI, K_JAL}) ? 0 : (c == K_LW) ? 2 : 1;
    t = t - (k - 1);
    return (k == 3 || t < 0) ? 0 : t;
  endfunction

  function automatic logic [31:0] r_ins(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rnd_ir();
    logic [4:0] a, b, c;
    logic [15:0] imm;
    logic [31:0] junk;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    imm = 16'($urandom);
    junk = $urandom;
    case ($urandom_range(0, 19))
      0: return r_ins(6'h21, a, b, c);
      1: return r_ins(6'h23, a, b, c);
      2: return i_ins(6'h0d, a, b, imm);
      3: return i_ins(6'h23, a, b, imm);
      4: return i_ins(6'h2b, a, b, imm);
      5: return i_ins(6'h0f, 5'd0, b, imm);
      6: return i_ins(6'h04, a, b, imm);
      7: return {6'h02, junk[25:0]};
      8: return {6'h03, junk[25:0]};
      9: return r_ins(6'h08, a, 5'd0, 5'd0);
      10: return r_ins(6'h18, a, b, 5'd0);
      11: return r_ins(6'h19, a, b, 5'd0);
      12: return r_ins(6'h1a, a, b, 5'd0);
      13: return r_ins(6'h1b, a, b, 5'd0);
      14: return r_ins(6'h10, 5'd0, 5'd0, c);
      15: return r_ins(6'h12, 5'd0, 5'd0, c);
      16: return r_ins(6'h11, a, 5'd0, 5'd0);
      17: return r_ins(6'h13, a, 5'd0, 5'd0);
      18: return 32'd0;
      default: return junk;
    endcase
  endfunction

  task automatic set(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m, input logic [31:0] w);
    hz.D_IR = d;
    hz.E_IR = e;
    hz.M_IR = m;
    hz.W_IR = w;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    if (reset) m_cnt = 0;
    else if (is_md(kind_of(hz.E_IR))) m_cnt = (kind_of(hz.E_IR) inside {K_DIV, K_DIVU}) ? 10 : 5;
    else if (m_cnt > 0) m_cnt--;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    logic [31:0] p [4];
    logic [4:0] src;
    int st, tu, fd, fe, fm;
    p[0] = hz.D_IR;
    p[1] = hz.E_IR;
    p[2] = hz.M_IR;
    p[3] = hz.W_IR;
    st = 0;
    for (int s = 0; s < 2; s++) begin
      src = s ? p[0][20:16] : p[0][25:21];
      tu = tuse_of(kind_of(p[0]), s);
      for (int k = 1; k < 3; k++)
        if (tu != NO_USE && dst_of(p[k]) != 0 && dst_of(p[k]) == int'(src) && tu < tnew_at(k, p[k])) st = 1;
    end
    if ((is_md(kind_of(p[0])) || kind_of(p[0]) inside {K_MFHI, K_MFLO, K_MTHI, K_MTLO}) &&
        (is_md(kind_of(p[1])) || m_cnt != 0)) st = 1;
    chk("stall", int'(hz.stall), st);
    chk("md_start", int'(hz.md_start), int'(is_md(kind_of(p[1]))));
    chk("md_busy", int'(hz.md_busy), int'(m_cnt != 0));
    for (int s = 0; s < 2; s++) begin
      src = s ? p[0][20:16] : p[0][25:21];
      fd = 0;
      for (int k = 3; k >= 1; k--)
        if (dst_of(p[k]) != 0 && dst_of(p[k]) == int'(src)) fd = (k == 3) ? 3 : (tnew_at(k, p[k]) == 0 ? k : 0);
      if (tuse_of(kind_of(p[0]), s) != NO_USE)
        chk(s ? "fwd_D_rt" : "fwd_D_rs", int'(s ? hz.fwd_D_rt : hz.fwd_D_rs), fd);
      src = s ? p[1][20:16] : p[1][25:21];
      fe = 0;
      for (int k = 3; k >= 2; k--)
        if (dst_of(p[k]) != 0 && dst_of(p[k]) == int'(src)) fe = k;
      if (tuse_of(kind_of(p[1]), s) != NO_USE)
        chk(s ? "fwd_E_rt" : "fwd_E_rs", int'(s ? hz.fwd_E_rt : hz.fwd_E_rs), fe);
    end
    fm = (kind_of(p[2]) == K_SW && dst_of(p[3]) != 0 && dst_of(p[3]) == int'(p[2][20:16])) ? 1 : 0;
    chk("fwd_M_rt", int'(hz.fwd_M_rt), fm);
  endtask

  initial begin
    logic [31:0] lw1, addu, lui4, ori4, beq4, dv, mflo, mult, mfhi;
    int n, b;
    lw1  = i_ins(6'h23, 5'd0, 5'd1, 16'd4);
    addu = r_ins(6'h21, 5'd1, 5'd3, 5'd2);
    lui4 = i_ins(6'h0f, 5'd0, 5'd4, 16'h1234);
    ori4 = i_ins(6'h0d, 5'd0, 5'd4, 16'h5);
    beq4 = i_ins(6'h04, 5'd4, 5'd0, 16'h8);
    dv   = r_ins(6'h1a, 5'd1, 5'd2, 5'd0);
    mult = r_ins(6'h18, 5'd1, 5'd2, 5'd0);
    mflo = r_ins(6'h12, 5'd0, 5'd0, 5'd7);
    mfhi = r_ins(6'h10, 5'd0, 5'd0, 5'd7);
    set(0, 0, 0, 0);
    hz2.D_IR = 0; hz2.E_IR = 0; hz2.M_IR = 0; hz2.W_IR = 0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_busy", int'(hz.md_busy), 0);
    chk("rst_stall", int'(hz.stall), 0);
    tick();
    // load-use
    set(addu, lw1, 0, 0); settle(); chk("lu_stall", int'(hz.stall), 1); check_all(); tick();
    set(addu, 0, lw1, 0); settle(); chk("lu_stall2", int'(hz.stall), 0); tick();
    set(0, addu, lw1, 0); settle(); chk("lu_fwdE_M", int'(hz.fwd_E_rs), 2); tick();
    set(0, addu, 0, lw1); settle(); chk("lu_fwdE_W", int'(hz.fwd_E_rs), 3); check_all(); tick();
    // branch operands
    set(beq4, lui4, 0, 0); settle();
    chk("br_lui_stall", int'(hz.stall), 0); chk("br_lui_fwd", int'(hz.fwd_D_rs), 1); tick();
    set(beq4, ori4, 0, 0); settle(); chk("br_ori_stall", int'(hz.stall), 1); tick();
    set(beq4, 0, ori4, 0); settle();
    chk("br_ori_stall2", int'(hz.stall), 0); chk("br_ori_fwd", int'(hz.fwd_D_rs), 2); tick();
    // $0 never forwards; store data from W
    set(i_ins(6'h04, 5'd0, 5'd0, 16'd1), 0, 0, r_ins(6'h21, 5'd1, 5'd2, 5'd0)); settle();
    chk("z_fwd_rs", int'(hz.fwd_D_rs), 0); chk("z_fwd_rt", int'(hz.fwd_D_rt), 0);
    chk("z_stall", int'(hz.stall), 0); tick();
    set(0, 0, i_ins(6'h2b, 5'd1, 5'd5, 16'd0), i_ins(6'h23, 5'd0, 5'd5, 16'd0)); settle();
    chk("sw_fwdM", int'(hz.fwd_M_rt), 1); check_all(); tick();
    // divide busy window
    set(mflo, dv, 0, 0); settle();
    chk("div_start", int'(hz.md_start), 1); chk("div_stall0", int'(hz.stall), 1); tick();
    set(mflo, 0, 0, 0);
    n = 1; b = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      if (!hz.stall) break;
      n++;
      b += int'(hz.md_busy);
      tick();
    end
    chk("div_busy_cycles", b, 10);
    chk("div_stall_cycles", n, 11);
    tick();
    // reset aborts multiply
    set(0, mult, 0, 0); settle(); tick();
    set(0, 0, 0, 0); settle(); tick();
    reset = 1'b1; settle(); tick();
    reset = 1'b0;
    set(mfhi, 0, 0, 0); settle();
    chk("rst_abort_busy", int'(hz.md_busy), 0);
    chk("rst_abort_stall", int'(hz.stall), 0);
    tick();
    // DIV_CYC=15 instance
    hz2.E_IR = dv; settle(); tick();
    hz2.E_IR = 0;
    b = 0;
    for (int i = 0; i < 30; i++) begin
      settle();
      b += int'(hz2.md_busy);
      tick();
    end
    chk("div15_busy_cycles", b, 15);
    // random pipelines
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 50) == 0);
      set(rnd_ir(), rnd_ir(), rnd_ir(), rnd_ir());
      settle();
      check_all();
      tick();
    end
    reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL provide parameter MULT_CYC, default 5, meaning busy cycles after a mult/multu leaves E.
REQ-002 SHALL provide parameter DIV_CYC, default 10, meaning busy cycles after a div/divu leaves E.
REQ-003 SHALL provide parameter CNT_W, default 4, meaning busy-counter width; it SHALL hold max(MULT_CYC, DIV_CYC).
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- D_IR, in, 32, instruction in D.
- E_IR, in, 32, instruction in E.
- M_IR, in, 32, instruction in M.
- W_IR, in, 32, instruction in W.
- stall, out, 1, freezes PC and F/D, bubbles D/E.
- md_start, out, 1, E holds mult/multu/div/divu this cycle.
- md_busy, out, 1, MD unit counting.
- fwd_D_rs, out, 2, D-stage rs source select.
- fwd_D_rt, out, 2, D-stage rt source select.
- fwd_E_rs, out, 2, E-stage rs source select.
- fwd_E_rt, out, 2, E-stage rt source select.
- fwd_M_rt, out, 1, M-stage rt source select.

Function
REQ-005 SHALL decode addu, subu, ori, lw, sw, lui, beq, j, jal, jr, mult, multu, div, divu, mfhi, mflo, mthi, mtlo with standard MIPS opcodes/functs; any other encoding, including nop, SHALL be treated as no read and no write.
REQ-006 SHALL use these destinations: rd for addu/subu/mfhi/mflo; rt for ori/lw/lui; register 31 for jal; none otherwise; destination 0 SHALL never match.
REQ-007 SHALL use these Tuse values: beq rs/rt=0; jr rs=0; addu/subu rs/rt=1; ori/lw/sw/mthi/mtlo rs=1; mult/multu/div/divu rs/rt=1; sw rt=2.
REQ-008 SHALL use these Tnew values at E: lui/jal=0; addu/subu/ori/mfhi/mflo=1; lw=2. Tnew at M = max(Tnew_E-1,0); Tnew at W = 0.
REQ-009 SHALL assert stall when a D source register matches the nonzero destination of E or M and Tuse < that stage's Tnew.
REQ-010 SHALL also assert stall when D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo and (md_start or md_busy).
REQ-011 fwd_D_*: 0=register file, 1=E result (Tnew_E=0), 2=M result (Tnew_M=0), 3=W result; SHALL use priority E>M>W; SHALL select 0 when the nearest match is not yet ready.
REQ-012 fwd_E_*: 0=pipe register, 2=M result, 3=W result; SHALL use priority M>W; codes are valid only for rs/rt actually read per REQ-007.
REQ-013 fwd_M_rt: 1 when M is sw and W writes M's rt (nonzero); otherwise 0.
REQ-014 Busy counter: SHALL load MULT_CYC or DIV_CYC on the edge where md_start=1; SHALL otherwise decrement while nonzero; md_busy = (counter != 0).
REQ-015 If md_start=1 while md_busy=1, SHALL reload the counter; REQ-010 prevents this under normal flow.
REQ-016 All outputs except md_busy SHALL be combinational from the IR inputs; stall SHALL be independent of fwd_*.

Reset
REQ-017 On reset at a clk edge, SHALL clear the counter to 0 and set md_busy=0 from the next cycle.
REQ-018 Reset SHALL take priority over md_start and abort any in-progress count.
REQ-019 Combinational outputs SHALL follow their inputs during reset.

Structure
REQ-020 Opcode/funct constants and the Tuse/Tnew encodings, including the fwd code values, SHALL live in a shared package, mips_defs.
REQ-021 A single sub-module, instr_class, SHALL decode one IR into class flags, destination register, Tuse and Tnew, instantiated once per stage.

Verification
REQ-022 E=lw $1, D=addu $2,$1,$3 -> stall=1 for one cycle; then M=lw $1 gives fwd_E_rs=2 on the next cycle, then 3.
REQ-023 E=lui $4, D=beq $4,$0 -> stall=0, fwd_D_rs=1; with E=ori $4 instead -> stall=1 one cycle, then fwd_D_rs=2.
REQ-024 E=div -> md_start=1; md_busy high for exactly 10 cycles; D=mflo stalls for 11 cycles total.
REQ-025 E=mult, then reset asserted 2 cycles later -> md_busy=0 the cycle after reset; D=mfhi not stalled.
REQ-026 W=addu $0 writing, D=beq $0,$0 -> fwd_D_*=0, stall=0; W=lw $5, M=sw $5 -> fwd_M_rt=1.
REQ-027 With DIV_CYC=15 and CNT_W=4 -> md_busy high for exactly 15 cycles.
